// File: rtl/ahb_write_master_fifo.sv
// AHB-Lite write-only master. Pixel requests are buffered in a FIFO and issued as pipelined NONSEQ singles.
// Optional macro AHB_ERR_CAPTURE_EN adds a sticky bus-error flag that records the first failing address.
module ahb_write_master_fifo #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              hclk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0] HADDR,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              busy,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clr
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [2:0] HSIZE_C = 3'($clog2(DATA_W / 8));

  logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic              empty_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;

  // Address stage holds zeros while invalid so it can drive the bus directly.
  logic              a_valid_r;
  logic [ADDR_W-1:0] a_addr_r;
  logic [DATA_W-1:0] a_data_r;
  logic              d_valid_r;
  logic [ADDR_W-1:0] d_addr_r;
  logic [DATA_W-1:0] d_data_r;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]) &&
                   (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]);
  assign push_s  = req_valid && !full_s;
  assign pop_s   = HREADY && !empty_s;

  // FIFO storage write port
  always_ff @(posedge hclk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r[IDX_W-1:0]] <= req_addr;
      fifo_data_r[wr_ptr_r[IDX_W-1:0]] <= req_data;
    end
  end

  // FIFO pointers with wrap bit
  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
    end
  end

  // Address/data pipeline, advancing only when the slave is ready
  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      a_valid_r <= 1'b0;
      a_addr_r  <= '0;
      a_data_r  <= '0;
      d_valid_r <= 1'b0;
      d_addr_r  <= '0;
      d_data_r  <= '0;
    end else if (HREADY) begin
      d_valid_r <= a_valid_r;
      d_addr_r  <= a_addr_r;
      d_data_r  <= a_data_r;
      a_valid_r <= !empty_s;
      if (!empty_s) begin
        a_addr_r <= fifo_addr_r[rd_ptr_r[IDX_W-1:0]];
        a_data_r <= fifo_data_r[rd_ptr_r[IDX_W-1:0]];
      end else begin
        a_addr_r <= '0;
        a_data_r <= '0;
      end
    end
  end

  assign req_ready = !full_s;
  assign HADDR     = a_addr_r;
  assign HWDATA    = d_data_r;
  assign HWRITE    = a_valid_r;
  assign HTRANS    = {a_valid_r, 1'b0};
  assign HSIZE     = HSIZE_C;
  assign busy      = !empty_s || a_valid_r || d_valid_r;

`ifdef AHB_ERR_CAPTURE_EN
  logic              err_flag_r;
  logic [ADDR_W-1:0] err_addr_r;

  // First error wins; a capture outranks a simultaneous clear
  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      err_flag_r <= 1'b0;
      err_addr_r <= '0;
    end else if (d_valid_r && HREADY && HRESP && !err_flag_r) begin
      err_flag_r <= 1'b1;
      err_addr_r <= d_addr_r;
    end else if (err_clr) begin
      err_flag_r <= 1'b0;
      err_addr_r <= '0;
    end
  end

  assign err_flag = err_flag_r;
  assign err_addr = err_addr_r;
`else
  logic unused_s;
  assign unused_s = ^{HRESP, err_clr, d_addr_r};
  assign err_flag = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: doc/ahb_write_master_fifo.md
Name: ahb_write_master_fifo

Overview:
- Parametrised AHB-Lite write-only master for the memory manager.
- Accepts pixel write requests (address + colour) through a valid/ready port and buffers them in a FIFO.
- Issues them as pipelined single NONSEQ transfers: the address phase of transfer N+1 overlaps the data phase of transfer N.
- Adds the HREADY wait-state hold, HTRANS/HSIZE, backpressure and a busy indication.

Parameters:
- ADDR_W, 32, address width (HADDR, req_addr).
- DATA_W, 32, data width (HWDATA, req_data); one of 8/16/32/64.
- FIFO_DEPTH, 4, request FIFO entries; power of two, >= 2.

Ports:
- hclk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  write request present.
- req_ready  output  1  FIFO can accept a request (= !full).
- req_addr  input  ADDR_W  pixel byte address.
- req_data  input  DATA_W  colour data.
- HADDR  output  ADDR_W  AHB address.
- HWDATA  output  DATA_W  AHB write data.
- HWRITE  output  1  AHB write strobe.
- HTRANS  output  2  AHB transfer type: IDLE=2'b00, NONSEQ=2'b10.
- HSIZE  output  3  AHB transfer size.
- HREADY  input  1  slave ready.
- HRESP  input  1  slave error response.
- busy  output  1  FIFO non-empty or any transfer in flight.
- err_flag  output  1  sticky bus-error flag (feature only).
- err_addr  output  ADDR_W  address of first errored transfer (feature only).
- err_clr  input  1  clears err_flag/err_addr (feature only).

Behaviour:
- Reset (rst=1, asynchronous):
  - FIFO emptied; address and data stages invalid.
  - Outputs: HADDR=0, HWDATA=0, HWRITE=0, HTRANS=IDLE, HSIZE constant, req_ready=1, busy=0, err_flag=0, err_addr=0.
  - Reset mid-transfer drops all pending and in-flight requests; no partial transfer is reissued.
- Push: occurs at a rising edge when req_valid && req_ready.
  - req_ready = !full (registered count). No push-through when full, even if a pop occurs the same cycle.
- Pipeline: two registered stages, address stage A and data stage D. Both advance only on a rising edge with HREADY=1. On that edge:
  - D <= A, valid if A was valid.
  - A <= FIFO head (pop) if FIFO non-empty, else A invalid.
  - Push and pop in the same edge are both honoured; count is unchanged.
- HREADY=0: A, D and all outputs hold unchanged; the FIFO may still accept pushes.
- Outputs:
  - A valid: HTRANS=NONSEQ, HWRITE=1, HADDR=A.addr.
  - A invalid: HTRANS=IDLE, HWRITE=0, HADDR=0.
  - D valid: HWDATA=D.data; otherwise HWDATA=0.
  - HSIZE = log2(DATA_W/8): 3'b010 for 32 bits.
- Latency: request pushed at edge k into an empty, idle master with HREADY=1:
  - address phase in cycle k+1 (after edge k+1);
  - data phase in cycle k+2;
  - complete at edge k+3 if HREADY=1.
- Throughput: one transfer per cycle with HREADY=1 and the FIFO kept non-empty.
- FIFO: circular read/write pointers, log2(FIFO_DEPTH)+1 bits with a wrap bit; full/empty derived from the pointers. Wraps naturally.
- busy = !empty || A.valid || D.valid.
- Without the optional feature, HRESP is ignored and the transfer completes normally.

Optional Feature:
- Macro: AHB_ERR_CAPTURE_EN.
- Defined:
  - At any edge with D valid, HRESP=1 and HREADY=1 (final error cycle), and err_flag=0: set err_flag=1 and err_addr = that transfer's address. D must therefore carry its address.
  - Later errors do not overwrite err_addr.
  - err_clr=1 clears both at the next edge. Error capture has priority over err_clr in the same cycle.
  - Transfers continue; none are retried.
- Undefined: err_flag=0 and err_addr=0 constantly; err_clr and HRESP unused.

Test Plan:
- Reset then idle -> HTRANS=00, HWRITE=0, req_ready=1, busy=0; assert rst mid-burst -> all outputs return to reset values within the same cycle.
- Single push addr=0x1000, data=0xDEADBEEF, HREADY=1 -> cycle k+1: HADDR=0x1000, HTRANS=10, HWRITE=1; cycle k+2: HWDATA=0xDEADBEEF, HTRANS=00; busy falls after edge k+3.
- Four back-to-back pushes 0x0/0x4/0x8/0xC with HREADY=1 -> NONSEQ on four consecutive cycles, each HWDATA one cycle behind its address, no IDLE gaps.
- HREADY=0 for 3 cycles during data phase of 0x4 -> HADDR=0x8 and HWDATA of 0x4 held stable for all 3 cycles; sequence resumes with nothing lost or duplicated.
- HREADY=0 while pushing 6 requests into DEPTH=4 -> req_ready=0 after the 4th push; the 5th is held by the source and accepted after the first pop; order preserved.
- With AHB_ERR_CAPTURE_EN, HRESP=1 on transfer 0x8 then on 0xC -> err_flag=1, err_addr=0x8; err_clr pulse -> both 0.
